// File: rtl/verlet_pkg.sv
// Shared types and default constants for the Verlet particle bank.
package verlet_pkg;

  localparam int FIX_W = 32;

  typedef logic signed [FIX_W-1:0] fix_t;

  localparam fix_t DEF_BASE_X      = 32'h000C8000;
  localparam fix_t DEF_SPACING     = 32'h0000A000;
  localparam fix_t DEF_GRAVITY     = 32'h000004CD;
  localparam fix_t DEF_X_MIN       = 32'h00000000;
  localparam fix_t DEF_X_MAX       = 32'h00280000;
  localparam fix_t DEF_Y_MIN       = 32'h00000000;
  localparam fix_t DEF_Y_MAX       = 32'h001E0000;
  localparam fix_t DEF_MOUSE_R     = 32'h00008000;
  localparam fix_t DEF_MOUSE_POWER = 32'h0000A000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/particle_mouse_probe.sv
// Combinational mouse capture test: box hit and which side of the particle
// the cursor is on.
module particle_mouse_probe #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] x_mouse,
  input  logic signed [W-1:0] y_mouse,
  input  logic signed [W-1:0] radius,
  output logic                hit,
  output logic                dir_pos
);

  logic signed [W-1:0] diff_x, diff_y, abs_x, abs_y;

  always_comb begin
    diff_x  = x_mouse - x;
    diff_y  = y_mouse - y;
    abs_x   = diff_x[W-1] ? -diff_x : diff_x;
    abs_y   = diff_y[W-1] ? -diff_y : diff_y;
    hit     = (abs_x < radius) && (abs_y < radius);
    dir_pos = (x_mouse >= x);
  end

endmodule

// File: rtl/verlet_particle_bank.sv
// Time-multiplexed two-stage Verlet integrator over N_NODES particles.
// Optional mouse drag impulse is built when MOUSE_DRAG_EN is defined.
module verlet_particle_bank
  import verlet_pkg::*;
#(
  parameter int                N_NODES     = 8,
  parameter int                W           = 32,
  parameter int                FRAC        = 12,
  parameter logic signed [W-1:0] BASE_X      = DEF_BASE_X,
  parameter logic signed [W-1:0] SPACING     = DEF_SPACING,
  parameter logic signed [W-1:0] GRAVITY     = DEF_GRAVITY,
  parameter int                DAMP_SHIFT  = 6,
  parameter logic signed [W-1:0] X_MIN       = DEF_X_MIN,
  parameter logic signed [W-1:0] X_MAX       = DEF_X_MAX,
  parameter logic signed [W-1:0] Y_MIN       = DEF_Y_MIN,
  parameter logic signed [W-1:0] Y_MAX       = DEF_Y_MAX,
  parameter logic signed [W-1:0] MOUSE_R     = DEF_MOUSE_R,
  parameter logic signed [W-1:0] MOUSE_POWER = DEF_MOUSE_POWER,
  localparam int               IW          = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic [N_NODES-1:0]  pin_mask,
  input  logic signed [W-1:0] x_mouse,
  input  logic signed [W-1:0] y_mouse,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic signed [W-1:0] wr_x,
  input  logic signed [W-1:0] wr_y,
  output logic                wr_ready,
  input  logic [IW-1:0]       rd_idx,
  output logic signed [W-1:0] rd_x,
  output logic signed [W-1:0] rd_y
);

  typedef logic signed [W-1:0] word_t;

  function automatic word_t clamp(input word_t v, input word_t lo, input word_t hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

  state_t        state_reg, state_next;
  logic [IW-1:0] issue_idx_reg, issue_idx_next;
  logic          issue_valid;
  logic          done_reg;
  logic          wr_accept;

  word_t x_arr [N_NODES];
  word_t y_arr [N_NODES];
  word_t px_arr[N_NODES];
  word_t py_arr[N_NODES];

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      issue_idx_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      issue_idx_reg <= issue_idx_next;
      done_reg      <= (state_reg == ST_DRAIN);
    end
  end

  always_comb begin
    state_next     = state_reg;
    issue_idx_next = issue_idx_reg;
    issue_valid    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_RUN;
          issue_idx_next = '0;
        end
      end
      ST_RUN: begin
        issue_valid = 1'b1;
        if (issue_idx_reg == IW'(N_NODES - 1)) state_next = ST_DRAIN;
        else issue_idx_next = issue_idx_reg + 1'b1;
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign wr_ready  = ~busy;
  assign wr_accept = wr_en && (state_reg == ST_IDLE);

  // ---------------- stage 1: read, velocity, damping, hit test ----------------
  word_t s1_x, s1_y, s1_px, s1_py, s1_vx, s1_vy, s1_dx, s1_dy;
  logic  s1_hit, s1_dir;

  always_comb begin
    s1_x  = x_arr[issue_idx_reg];
    s1_y  = y_arr[issue_idx_reg];
    s1_px = px_arr[issue_idx_reg];
    s1_py = py_arr[issue_idx_reg];
    s1_vx = s1_x - s1_px;
    s1_vy = s1_y - s1_py;
    s1_dx = (DAMP_SHIFT == 0) ? s1_vx : s1_vx - (s1_vx >>> DAMP_SHIFT);
    s1_dy = (DAMP_SHIFT == 0) ? s1_vy : s1_vy - (s1_vy >>> DAMP_SHIFT);
  end

`ifdef MOUSE_DRAG_EN
  particle_mouse_probe #(.W(W)) u_probe (
    .x       (s1_x),
    .y       (s1_y),
    .x_mouse (x_mouse),
    .y_mouse (y_mouse),
    .radius  (MOUSE_R),
    .hit     (s1_hit),
    .dir_pos (s1_dir)
  );
`else
  logic unused_mouse;
  assign unused_mouse = ^{x_mouse, y_mouse, MOUSE_R, MOUSE_POWER};
  assign s1_hit = 1'b0;
  assign s1_dir = 1'b0;
`endif

  logic          s2_valid, s2_pin, s2_hit, s2_dir;
  logic [IW-1:0] s2_idx;
  word_t         s2_x, s2_y, s2_dx, s2_dy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_pin   <= 1'b0;
      s2_hit   <= 1'b0;
      s2_dir   <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_dx    <= '0;
      s2_dy    <= '0;
    end else begin
      s2_valid <= issue_valid;
      s2_idx   <= issue_idx_reg;
      s2_pin   <= pin_mask[issue_idx_reg];
      s2_hit   <= s1_hit;
      s2_dir   <= s1_dir;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_dx    <= s1_dx;
      s2_dy    <= s1_dy;
    end
  end

  // ---------------- stage 2: integrate, clamp, impulse ----------------
  word_t sum_x, sum_y, nx, ny, npx, npy;

  always_comb begin
    sum_x = s2_x + s2_dx;
    sum_y = s2_y + s2_dy + GRAVITY;
    npy   = s2_y;
    if (s2_pin) begin
      nx  = s2_x;
      ny  = s2_y;
      npx = s2_x;
    end else begin
      nx  = clamp(sum_x, X_MIN, X_MAX);
      ny  = clamp(sum_y, Y_MIN, Y_MAX);
      npx = s2_x;
`ifdef MOUSE_DRAG_EN
      // A fake previous position injects velocity away from the cursor.
      if (s2_hit) npx = s2_dir ? s2_x + MOUSE_POWER : s2_x - MOUSE_POWER;
`endif
    end
  end

  // ---------------- particle state ----------------
  for (genvar gi = 0; gi < N_NODES; gi++) begin : g_node
    localparam word_t RST_Y = word_t'(SPACING * (gi + 1));
    word_t x_q, y_q, px_q, py_q;
    logic  upd, wr_hit;

    assign upd    = s2_valid && (s2_idx == IW'(gi));
    assign wr_hit = wr_accept && (wr_idx == IW'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        x_q  <= BASE_X;
        y_q  <= RST_Y;
        px_q <= BASE_X;
        py_q <= RST_Y;
      end else if (upd) begin
        x_q  <= nx;
        y_q  <= ny;
        px_q <= npx;
        py_q <= npy;
      end else if (wr_hit) begin
        x_q <= wr_x;
        y_q <= wr_y;
      end
    end

    assign x_arr[gi]  = x_q;
    assign y_arr[gi]  = y_q;
    assign px_arr[gi] = px_q;
    assign py_arr[gi] = py_q;
  end

  assign rd_x = x_arr[rd_idx];
  assign rd_y = y_arr[rd_idx];

endmodule

// File: tb/tb_verlet_particle_bank.sv
// Directed self-checking bench for verlet_particle_bank (N_NODES=4, no damping).
module tb_verlet_particle_bank;

  localparam int N = 4;
  localparam logic [31:0] G = 32'h000004CD;

  logic        clk, reset, start, busy, done, wr_en, wr_ready;
  logic [N-1:0] pin_mask;
  logic [31:0] x_mouse, y_mouse, wr_x, wr_y, rd_x, rd_y;
  logic [1:0]  wr_idx, rd_idx;

  int tests = 0;
  int fails = 0;

  verlet_particle_bank #(.N_NODES(N), .DAMP_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pin_mask(pin_mask), .x_mouse(x_mouse), .y_mouse(y_mouse),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_ready(wr_ready), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic do_reset();
    reset = 0; start = 0; wr_en = 0; pin_mask = '0;
    x_mouse = 0; y_mouse = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
  endtask

  // Pulse start, then watch a bounded window for done.
  task automatic run_step(output int done_at, output int n_done,
                          output logic b1, output logic bd);
    done_at = -1; n_done = 0; bd = 1'b1;
    start = 1;
    @(posedge clk); #1;
    start = 0; wr_en = 0;
    b1 = busy;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (done_at < 0) begin done_at = n; bd = busy; end
      end
    end
  endtask

  task automatic read_node(input int i, output logic [31:0] x, output logic [31:0] y);
    rd_idx = 2'(i); #1;
    x = rd_x; y = rd_y;
  endtask

  int da, nd, cnt;
  logic b1, bd;
  logic [31:0] rx, ry;

  initial begin
    reset = 0; start = 0; pin_mask = '0; x_mouse = 0; y_mouse = 0;
    wr_en = 0; wr_idx = 0; wr_x = 0; wr_y = 0; rd_idx = 2;
    do_reset();

    // Reset state
    read_node(2, rx, ry);
    check_val("rst_x2", rx, 32'h000C8000);
    check_val("rst_y2", ry, 32'h0001E000);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_wr_ready", 32'(wr_ready), 1);

    // Free fall, two steps
    run_step(da, nd, b1, bd);
    check_val("s1_done_cycle", 32'(da), 5);
    check_val("s1_done_count", 32'(nd), 1);
    check_val("s1_busy_c1", 32'(b1), 1);
    check_val("s1_busy_at_done", 32'(bd), 0);
    for (int i = 0; i < N; i++) begin
      read_node(i, rx, ry);
      check_val($sformatf("s1_y%0d", i), ry, 32'h0000A000 * (i + 1) + G);
      check_val($sformatf("s1_x%0d", i), rx, 32'h000C8000);
    end
    run_step(da, nd, b1, bd);
    for (int i = 0; i < N; i++) begin
      read_node(i, rx, ry);
      check_val($sformatf("s2_y%0d", i), ry, 32'h0000A000 * (i + 1) + 3 * G);
    end

    // Pinning particle 0 over three steps
    do_reset();
    pin_mask = 4'b0001;
    repeat (3) run_step(da, nd, b1, bd);
    read_node(0, rx, ry);
    check_val("pin_y0", ry, 32'h0000A000);
    check_val("pin_x0", rx, 32'h000C8000);
    read_node(1, rx, ry);
    check_val("pin_y1", ry, 32'h00015CCE);
    read_node(3, rx, ry);
    check_val("pin_y3", ry, 32'h00029CCE);

    // Mouse capture of particle 1
    do_reset();
    x_mouse = 32'h000C9000; y_mouse = 32'h00014000;
    run_step(da, nd, b1, bd);
    read_node(1, rx, ry);
    check_val("mouse_s1_x1", rx, 32'h000C8000);
    run_step(da, nd, b1, bd);
    read_node(1, rx, ry);
`ifdef MOUSE_DRAG_EN
    check_val("mouse_s2_x1", rx, 32'h000BE000);
`else
    check_val("mouse_s2_x1", rx, 32'h000C8000);
`endif
    check_val("mouse_s2_y1", ry, 32'h00014E67);
    read_node(0, rx, ry);
    check_val("mouse_s2_x0", rx, 32'h000C8000);

    // Constraint writes
    do_reset();
    wr_en = 1; wr_idx = 2; wr_x = 32'h00050000; wr_y = 32'h0001E000;
    @(posedge clk); #1 wr_en = 0;
    read_node(2, rx, ry);
    check_val("wr_visible_x2", rx, 32'h00050000);
    wr_en = 1; wr_idx = 3; wr_x = 32'h00100000; wr_y = 32'h00028000;
    run_step(da, nd, b1, bd);
    read_node(3, rx, ry);
    check_val("wr_start_x3", rx, 32'h00138000);
    check_val("wr_start_y3", ry, 32'h000284CD);
    read_node(2, rx, ry);
    check_val("clamp_x2", rx, 32'h00000000);
    check_val("clamp_y2", ry, 32'h0001E4CD);

    // Write and start while busy are ignored
    start = 1;
    @(posedge clk); #1 start = 0;
    check_val("busy_wr_ready", 32'(wr_ready), 0);
    wr_en = 1; wr_idx = 0; wr_x = 32'h00012345; wr_y = 32'h00000777;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0; wr_en = 0;
    cnt = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check_val("busy_done_once", 32'(cnt), 1);
    read_node(0, rx, ry);
    check_val("busy_wr_drop_x0", rx, 32'h000C8000);
    check_val("busy_wr_drop_y0", ry, 32'h0000AE67);

    // Reset in cycle 3 of a step aborts it
    do_reset();
    rd_idx = 0;
    start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk);
    @(posedge clk); #1;
    check_val("abort_pre_y0", rd_y, 32'h0000A4CD);
    reset = 0; #1;
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_y0", rd_y, 32'h0000A000);
    @(posedge clk); #1 reset = 1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check_val("abort_no_done", 32'(cnt), 0);
    read_node(1, rx, ry);
    check_val("abort_y1", ry, 32'h00014000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
